// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: applies one 1-bit right step per clock, with valid/ready on both sides.
// Optional rotate-right mode is compiled in when SEQSHR_ROTATE_EN is defined.
module seq_right_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   amt,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   count_q;
  logic             mode_q;

  logic             mode_d;
  logic             fill_bit;
  logic [WIDTH-1:0] step_d;

`ifdef SEQSHR_ROTATE_EN
  assign mode_d = mode;
`else
  // Logical-only build: mode_q is constant 0, so the rotate feedback folds away.
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_d      = 1'b0;
`endif

  assign fill_bit = mode_q & data_q[0];
  assign step_d   = {fill_bit, data_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q  <= data_in;
            count_q <= amt;
            mode_q  <= mode_d;
            state_q <= (amt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          data_q  <= step_d;
          count_q <= count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed testbench for seq_right_shifter: shift/rotate results, latency, backpressure and reset abort.
// Rotate expectations follow whether SEQSHR_ROTATE_EN is defined for this build.
module tb_seq_right_shifter;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   amt;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             busy;

  int n_cmp;
  int n_bad;

  seq_right_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand, wait for the accept edge, then scramble the inputs
  // so any late sampling by the DUT shows up as a wrong result.
  task automatic start_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a, input logic m);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    amt      = a;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = ~d;
    amt      = ~a;
    mode     = ~m;
  endtask

  // Count edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({data_out, out_valid, busy, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: data_out=%h out_valid=%b busy=%b in_ready=%b, required 00 0 0 1",
               data_out, out_valid, busy, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                        input logic m, input logic [WIDTH-1:0] exp_d, input int exp_edges);
    int edges;
    out_ready = 1'b1;
    start_op(d, a, m);
    wait_done(edges);
    n_cmp++;
    if (edges !== exp_edges || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_latency: edges=%0d out_valid=%b, required %0d 1", name, edges, out_valid, exp_edges);
    end
    n_cmp++;
    if (data_out !== exp_d) begin
      n_bad++;
      $display("FAIL %s_data: data_out=%b, required %b", name, data_out, exp_d);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_return_idle: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               name, in_ready, out_valid, busy);
    end
    $display("op %s: data_out=%b edges=%0d", name, data_out, edges);
  endtask

  task automatic test_logical;
    run_op("logical", 8'b1011_0010, 3'd3, 1'b0, 8'b0001_0110, 4);
  endtask

  task automatic test_rotate;
`ifdef SEQSHR_ROTATE_EN
    run_op("rotate", 8'b1011_0010, 3'd3, 1'b1, 8'b0101_0110, 4);
`else
    run_op("rotate", 8'b1011_0010, 3'd3, 1'b1, 8'b0001_0110, 4);
`endif
  endtask

  task automatic test_zero_shift;
    run_op("zero", 8'hA5, 3'd0, 1'b0, 8'hA5, 1);
  endtask

  task automatic test_max_shift;
    run_op("max", 8'h80, 3'd7, 1'b0, 8'h01, 8);
  endtask

  task automatic test_backpressure;
    int edges;
    out_ready = 1'b0;
    start_op(8'h3C, 3'd2, 1'b0);
    wait_done(edges);
    n_cmp++;
    if (edges !== 3 || data_out !== 8'h0F) begin
      n_bad++;
      $display("FAIL bp_first_result: edges=%0d data_out=%h, required 3 0f", edges, data_out);
    end
    in_valid = 1'b1;
    data_in  = 8'hAA;
    amt      = 3'd1;
    mode     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (data_out !== 8'h0F || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: data_out=%h out_valid=%b in_ready=%b busy=%b, required 0f 1 0 1",
                 i, data_out, out_valid, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h0F) begin
      n_bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b data_out=%h, required 1 0 0f",
               in_ready, out_valid, data_out);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || data_out !== 8'hAA) begin
      n_bad++;
      $display("FAIL bp_new_accept: busy=%b in_ready=%b data_out=%h, required 1 0 aa",
               busy, in_ready, data_out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || data_out !== 8'h55) begin
      n_bad++;
      $display("FAIL bp_new_result: out_valid=%b data_out=%h, required 1 55", out_valid, data_out);
    end
    @(posedge clk);
    #1;
    $display("op backpressure: final data_out=%h in_ready=%b", data_out, in_ready);
  endtask

  task automatic test_reset_mid_shift;
    out_ready = 1'b1;
    start_op(8'hFF, 3'd7, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (data_out !== 8'h1F || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_partial: data_out=%h busy=%b, required 1f 1", data_out, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({data_out, out_valid, busy, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_async: data_out=%h out_valid=%b busy=%b in_ready=%b, required 00 0 0 1",
               data_out, out_valid, busy, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_after: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    run_op("after_reset", 8'h0F, 3'd2, 1'b0, 8'h03, 3);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    amt       = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_logical;
    test_rotate;
    test_zero_shift;
    test_max_shift;
    test_backpressure;
    test_reset_mid_shift;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_right_shifter.md
Name: seq_right_shifter

Overview:
- Multi-cycle right shifter/rotator. It performs the opposite direction to the team's combinational left barrel shifter, using one 1-bit shift step per clock.
- Sits beside the combinational shifter in the HW1 datapath experiments. It takes an operand and a shift amount over a valid/ready input handshake and returns the result over a valid/ready output handshake.
- Trades latency for area: a single 1-bit shift stage plus a down-counter replaces the log2 mux tree.

Parameters:
- WIDTH, 8, data width in bits.
- SHW, 3, shift-amount width; shift range is 0..2^SHW-1. Must satisfy 2^SHW <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand present on data_in/amt/mode.
- in_ready  output  1  block can accept an operand. High only in IDLE.
- data_in  input  WIDTH  operand.
- amt  input  SHW  shift amount.
- mode  input  1  0 = logical right shift (zero fill), 1 = rotate right (see Optional Feature).
- out_valid  output  1  result valid on data_out.
- out_ready  input  1  consumer accepts the result.
- data_out  output  WIDTH  result register.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, data_out=0, count=0, mode_q=0, out_valid=0, busy=0, in_ready=1.
- in_ready, out_valid and busy are decoded combinationally from the state register only.
- States and transitions:
  - IDLE: in_ready=1. On an edge with in_valid=1, accept: data_out<=data_in, count<=amt, mode_q<=mode. Next state is DONE if amt==0, else SHIFT. With in_valid=0, stay in IDLE.
  - SHIFT: each edge applies one step to data_out and decrements count.
    - Logical step: {1'b0, data_out[WIDTH-1:1]}.
    - Rotate step: {data_out[0], data_out[WIDTH-1:1]}.
    - When count==1 on that edge, next state is DONE; otherwise stay in SHIFT.
    - in_valid is ignored.
  - DONE: out_valid=1, data_out held stable. On an edge with out_ready=1, next state is IDLE. in_valid is ignored.
- Latency from the accept edge to out_valid visible:
  - amt=0: 1 edge.
  - amt=k (k>0): k+1 edges, i.e. the accept edge plus k shift edges.
- Throughput: one operation per latency+1 cycles minimum, because IDLE is revisited for one cycle after each result.
- No pipelining and no overlap: a new operand is never accepted while busy=1.
- data_out changes only on the accept edge and on shift edges. It never changes while out_valid=1.
- Width rules:
  - count is SHW bits.
  - Maximum amt=2^SHW-1. For a logical shift with amt >= WIDTH this is not reachable given the SHW constraint.
  - No sign extension.
- Inputs data_in/amt/mode are sampled only on the accept edge. Changes on them at other times have no effect.
- Reset mid-operation (in SHIFT or DONE): abort immediately to the reset values. The partial result is discarded and out_valid is never raised for the aborted operation.

Optional Feature:
- Macro SEQSHR_ROTATE_EN.
- Defined: the mode input is honoured, and mode=1 gives rotate right.
- Not defined: mode is ignored and mode_q is tied to 0. Every operation is a logical right shift, and the rotate datapath is not synthesized.
- Port list is identical in both builds.

Test Plan:
- Logical shift: data_in=8'b1011_0010, amt=3, mode=0, out_ready=1. Expect data_out=8'b0001_0110 with out_valid high exactly 4 edges after accept, then in_ready=1 on the next cycle.
- Rotate, with SEQSHR_ROTATE_EN defined: data_in=8'b1011_0010, amt=3, mode=1. Expect 8'b0101_0110 after 4 edges. Without the macro, the same stimulus gives 8'b0001_0110.
- Zero shift: data_in=8'hA5, amt=0. Expect out_valid and data_out=8'hA5 1 edge after accept.
- Maximum shift: data_in=8'h80, amt=7, mode=0. Expect 8'h01 after 8 edges.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and a new data_in. Expect data_out held, out_valid=1, in_ready=0, and no new accept. Raise out_ready: IDLE on the next edge, and the new operand is accepted one edge later.
- Reset mid-shift: start data_in=8'hFF, amt=7, then assert rst for 1 cycle after 3 shift edges. Expect immediately (asynchronously) data_out=0, out_valid=0, busy=0, in_ready=1. Then a fresh operation 8'h0F, amt=2 returns 8'h03.
